// File: rtl/mc_controller_ext_pkg.sv
// Shared declarations for the extended multicycle MIPS controller:
// opcode/funct encodings, FSM state type and ALU control codes.
package mips_decls_p;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000,
    OP_SLTI  = 6'b001010,
    OP_ANDI  = 6'b001100,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_t;

  typedef enum logic [5:0] {
    F_ADD = 6'b100000,
    F_SUB = 6'b100010,
    F_AND = 6'b100100,
    F_OR  = 6'b100101,
    F_SLT = 6'b101010
  } funct_t;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB,
    BEQEX, BNEEX, IMMEX, IMMWB, JEX, ILLEGAL
  } statetype_t;

  typedef enum logic [2:0] {
    ALUOP_AND, ALUOP_ADD, ALUOP_SUB, ALUOP_OR, ALUOP_SLT, ALUOP_FUNCT
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_ext_aludec.sv
// ALU decoder: maps the FSM's ALU request and the R-type funct field to
// alucontrol, and flags whether funct is one of the supported R-type ops.
module mc_aludec
  import mips_decls_p::*;
(
  input  aluop_t      aluop_i,
  input  funct_t      funct_i,
  output logic [2:0]  alucontrol_o,
  output logic        functValid_o
);

  logic [2:0] rtypeCtl;

  always_comb begin
    functValid_o = 1'b1;
    rtypeCtl     = ALU_AND;
    case (funct_i)
      F_ADD:   rtypeCtl = ALU_ADD;
      F_SUB:   rtypeCtl = ALU_SUB;
      F_AND:   rtypeCtl = ALU_AND;
      F_OR:    rtypeCtl = ALU_OR;
      F_SLT:   rtypeCtl = ALU_SLT;
      default: functValid_o = 1'b0;
    endcase
  end

  always_comb begin
    alucontrol_o = ALU_AND;
    case (aluop_i)
      ALUOP_ADD:   alucontrol_o = ALU_ADD;
      ALUOP_SUB:   alucontrol_o = ALU_SUB;
      ALUOP_OR:    alucontrol_o = ALU_OR;
      ALUOP_SLT:   alucontrol_o = ALU_SLT;
      ALUOP_FUNCT: alucontrol_o = rtypeCtl;
      default:     alucontrol_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mc_controller_ext.sv
// Multicycle MIPS control unit: Moore FSM sequencing the datapath, with
// I-type ALU ops, BNE, optional memory wait states and a sticky illegal trap.
module mc_controller_ext
  import mips_decls_p::*;
#(
  parameter bit MEM_WAIT_EN = 1'b0,
  parameter bit EXT_ISA     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  opcode_t     opcode,
  input  funct_t      funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pcen,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regwrite,
  output logic        alusrca,
  output logic        iord,
  output logic        memtoreg,
  output logic        regdst,
  output logic        extsel,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alucontrol,
  output logic        illegal,
  output statetype_t  state
);

  statetype_t state_q, state_d, curState;
  aluop_t     aluop, immOp;
  logic       ready, pcwrite, branch, branchne, irwriteRaw;
  logic       functValid, zeroExt;

  // While reset is held the outputs decode as FETCH, so no stale state leaks out.
  assign ready    = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign curState = reset ? FETCH : state_q;
  assign state    = curState;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    immOp   = ALUOP_ADD;
    zeroExt = 1'b0;
    case (opcode)
      OP_ANDI: begin immOp = ALUOP_AND; zeroExt = 1'b1; end
      OP_ORI:  begin immOp = ALUOP_OR;  zeroExt = 1'b1; end
      OP_SLTI: immOp = ALUOP_SLT;
      default: immOp = ALUOP_ADD;
    endcase
  end

  always_comb begin
    state_d    = curState;
    aluop      = ALUOP_AND;
    irwriteRaw = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branchne   = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    extsel     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    illegal    = 1'b0;
    case (curState)
      FETCH: begin
        alusrcb    = 2'b01;
        aluop      = ALUOP_ADD;
        irwriteRaw = ready;
        pcwrite    = ready;
        if (ready) state_d = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        aluop   = ALUOP_ADD;
        case (opcode)
          OP_LW, OP_SW:                      state_d = MEMADR;
          OP_RTYPE:                          state_d = functValid ? RTYPEEX : ILLEGAL;
          OP_BEQ:                            state_d = BEQEX;
          OP_BNE:                            state_d = EXT_ISA ? BNEEX : ILLEGAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = EXT_ISA ? IMMEX : ILLEGAL;
          OP_J:                              state_d = JEX;
          default:                           state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = ALUOP_ADD;
        state_d = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord = 1'b1;
        if (ready) state_d = MEMWB;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        if (ready) state_d = FETCH;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      BEQEX, BNEEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = 2'b01;
        branch   = (curState == BEQEX);
        branchne = (curState == BNEEX);
        state_d  = FETCH;
      end
      IMMEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = immOp;
        extsel  = zeroExt;
        state_d = IMMWB;
      end
      IMMWB: begin
        extsel   = zeroExt;
        regwrite = 1'b1;
        state_d  = FETCH;
      end
      JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
        state_d = FETCH;
      end
      ILLEGAL: begin
        illegal = 1'b1;
        state_d = ILLEGAL;
      end
      default: state_d = FETCH;
    endcase
  end

  assign pcen    = !reset & (pcwrite | (branch & zero) | (branchne & !zero));
  assign irwrite = !reset & irwriteRaw;

  mc_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol),
    .functValid_o (functValid)
  );

endmodule

// File: tb/tb_mc_controller_ext.sv
// Scoreboard bench for mc_controller_ext: one instance with wait states and
// the extended ISA, one without either, checked cycle by cycle.
module tb_mc_controller_ext;
  import mips_decls_p::*;

  typedef struct packed {
    logic pcen, irwrite, memwrite, regwrite, alusrca, iord, memtoreg, regdst, extsel;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic illegal;
  } ctl_t;

  typedef struct packed {
    statetype_t st;
    ctl_t       ctl;
    logic       chk2;
    statetype_t st2;
    ctl_t       ctl2;
  } exp_t;

  logic clk, reset, zero, memReady;
  opcode_t opcode;
  funct_t funct;

  logic pcenA, memwriteA, irwriteA, regwriteA, alusrcaA, iordA, memtoregA, regdstA, extselA, illegalA;
  logic [1:0] alusrcbA, pcsrcA;
  logic [2:0] alucontrolA;
  statetype_t stateA;
  logic pcenB, memwriteB, irwriteB, regwriteB, alusrcaB, iordB, memtoregB, regdstB, extselB, illegalB;
  logic [1:0] alusrcbB, pcsrcB;
  logic [2:0] alucontrolB;
  statetype_t stateB;
  ctl_t ctlA, ctlB;

  int vectors = 0;
  int miscompares = 0;
  exp_t expQ[$];
  string lbl;
  opcode_t curOp;
  funct_t curFn;

  mc_controller_ext #(.MEM_WAIT_EN(1'b1), .EXT_ISA(1'b1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(memReady),
    .pcen(pcenA), .memwrite(memwriteA), .irwrite(irwriteA), .regwrite(regwriteA),
    .alusrca(alusrcaA), .iord(iordA), .memtoreg(memtoregA), .regdst(regdstA), .extsel(extselA),
    .alusrcb(alusrcbA), .pcsrc(pcsrcA), .alucontrol(alucontrolA), .illegal(illegalA), .state(stateA)
  );

  mc_controller_ext #(.MEM_WAIT_EN(1'b0), .EXT_ISA(1'b0)) dutBase (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(memReady),
    .pcen(pcenB), .memwrite(memwriteB), .irwrite(irwriteB), .regwrite(regwriteB),
    .alusrca(alusrcaB), .iord(iordB), .memtoreg(memtoregB), .regdst(regdstB), .extsel(extselB),
    .alusrcb(alusrcbB), .pcsrc(pcsrcB), .alucontrol(alucontrolB), .illegal(illegalB), .state(stateB)
  );

  assign ctlA = '{pcenA, irwriteA, memwriteA, regwriteA, alusrcaA, iordA, memtoregA, regdstA,
                  extselA, alusrcbA, pcsrcA, alucontrolA, illegalA};
  assign ctlB = '{pcenB, irwriteB, memwriteB, regwriteB, alusrcaB, iordB, memtoregB, regdstB,
                  extselB, alusrcbB, pcsrcB, alucontrolB, illegalB};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected control vectors per state, written straight from the state table.
  function automatic ctl_t resetV();
    ctl_t c = '0; c.alusrcb = 2'b01; c.alucontrol = 3'b010; return c;
  endfunction
  function automatic ctl_t fetchV(logic rdy);
    ctl_t c = resetV(); c.pcen = rdy; c.irwrite = rdy; return c;
  endfunction
  function automatic ctl_t decodeV();
    ctl_t c = '0; c.alusrcb = 2'b11; c.alucontrol = 3'b010; return c;
  endfunction
  function automatic ctl_t memadrV();
    ctl_t c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = 3'b010; return c;
  endfunction
  function automatic ctl_t memrdV();
    ctl_t c = '0; c.iord = 1'b1; return c;
  endfunction
  function automatic ctl_t memwbV();
    ctl_t c = '0; c.memtoreg = 1'b1; c.regwrite = 1'b1; return c;
  endfunction
  function automatic ctl_t memwrV();
    ctl_t c = '0; c.iord = 1'b1; c.memwrite = 1'b1; return c;
  endfunction
  function automatic ctl_t rtexV(logic [2:0] alu);
    ctl_t c = '0; c.alusrca = 1'b1; c.alucontrol = alu; return c;
  endfunction
  function automatic ctl_t rtwbV();
    ctl_t c = '0; c.regdst = 1'b1; c.regwrite = 1'b1; return c;
  endfunction
  function automatic ctl_t brV(logic taken);
    ctl_t c = '0; c.alusrca = 1'b1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = taken; return c;
  endfunction
  function automatic ctl_t immexV(logic [2:0] alu, logic ext);
    ctl_t c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.alucontrol = alu; c.extsel = ext; return c;
  endfunction
  function automatic ctl_t immwbV(logic ext);
    ctl_t c = '0; c.regwrite = 1'b1; c.extsel = ext; return c;
  endfunction
  function automatic ctl_t jexV();
    ctl_t c = '0; c.pcsrc = 2'b10; c.pcen = 1'b1; return c;
  endfunction
  function automatic ctl_t illV();
    ctl_t c = '0; c.illegal = 1'b1; return c;
  endfunction

  function automatic exp_t one(statetype_t s, ctl_t c);
    exp_t e = '0; e.st = s; e.ctl = c; e.chk2 = 1'b0; return e;
  endfunction
  function automatic exp_t pair(statetype_t s, ctl_t c, statetype_t s2, ctl_t c2);
    exp_t e; e.st = s; e.ctl = c; e.chk2 = 1'b1; e.st2 = s2; e.ctl2 = c2; return e;
  endfunction
  function automatic exp_t both(statetype_t s, ctl_t c);
    return pair(s, c, s, c);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, queue its expectation, then score the DUT response.
  task automatic applyStimulus(input logic rdy, input logic z, input logic rst, input exp_t e);
    exp_t got;
    opcode = curOp; funct = curFn; memReady = rdy; zero = z; reset = rst;
    expQ.push_back(e);
    #1;
    got = expQ.pop_front();
    checkOutput({lbl, ".state"}, 32'(stateA), 32'(got.st));
    checkOutput({lbl, ".ctl"}, 32'(ctlA), 32'(got.ctl));
    if (got.chk2) begin
      checkOutput({lbl, ".base.state"}, 32'(stateB), 32'(got.st2));
      checkOutput({lbl, ".base.ctl"}, 32'(ctlB), 32'(got.ctl2));
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic startInstr(input string name, input opcode_t op, input funct_t fn);
    lbl = name; curOp = op; curFn = fn;
    applyStimulus(1'b1, 1'b0, 1'b1, both(FETCH, resetV()));
    applyStimulus(1'b1, 1'b0, 1'b0, both(FETCH, fetchV(1'b1)));
    applyStimulus(1'b1, 1'b0, 1'b0, both(DECODE, decodeV()));
  endtask

  opcode_t brOps[4]   = '{OP_BNE, OP_BNE, OP_BEQ, OP_BEQ};
  logic    brZero[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic    brTaken[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  opcode_t immOps[4]  = '{OP_ORI, OP_ADDI, OP_ANDI, OP_SLTI};
  logic [2:0] immAlu[4] = '{3'b001, 3'b010, 3'b000, 3'b111};
  logic    immExt[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
  funct_t  rFn[4]     = '{F_SUB, F_OR, F_AND, F_SLT};
  logic [2:0] rAlu[4] = '{3'b110, 3'b001, 3'b000, 3'b111};

  initial begin
    reset = 1'b1; opcode = OP_RTYPE; funct = F_ADD; zero = 1'b0; memReady = 1'b1;
    curOp = OP_RTYPE; curFn = F_ADD; lbl = "init";
    @(negedge clk);

    startInstr("radd", OP_RTYPE, F_ADD);
    applyStimulus(1'b1, 1'b0, 1'b0, both(RTYPEEX, rtexV(3'b010)));
    applyStimulus(1'b1, 1'b0, 1'b0, both(RTYPEWB, rtwbV()));
    applyStimulus(1'b1, 1'b0, 1'b0, both(FETCH, fetchV(1'b1)));

    for (int i = 0; i < 4; i++) begin
      startInstr($sformatf("rtype%0d", i), OP_RTYPE, rFn[i]);
      applyStimulus(1'b1, 1'b0, 1'b0, both(RTYPEEX, rtexV(rAlu[i])));
    end

    // LW with two stalled FETCH cycles and three stalled MEMRD cycles
    lbl = "lwstall"; curOp = OP_LW; curFn = F_ADD;
    applyStimulus(1'b1, 1'b0, 1'b1, both(FETCH, resetV()));
    applyStimulus(1'b0, 1'b0, 1'b0, one(FETCH, fetchV(1'b0)));
    applyStimulus(1'b0, 1'b0, 1'b0, one(FETCH, fetchV(1'b0)));
    applyStimulus(1'b1, 1'b0, 1'b0, one(FETCH, fetchV(1'b1)));
    applyStimulus(1'b0, 1'b0, 1'b0, one(DECODE, decodeV()));
    applyStimulus(1'b0, 1'b0, 1'b0, one(MEMADR, memadrV()));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, one(MEMRD, memrdV()));
    applyStimulus(1'b1, 1'b0, 1'b0, one(MEMRD, memrdV()));
    applyStimulus(1'b0, 1'b0, 1'b0, one(MEMWB, memwbV()));
    applyStimulus(1'b1, 1'b0, 1'b0, one(FETCH, fetchV(1'b1)));

    for (int i = 0; i < 4; i++) begin
      startInstr($sformatf("branch%0d", i), brOps[i], F_ADD);
      applyStimulus(1'b1, brZero[i], 1'b0,
                    one((brOps[i] == OP_BNE) ? BNEEX : BEQEX, brV(brTaken[i])));
      applyStimulus(1'b1, brZero[i], 1'b0, one(FETCH, fetchV(1'b1)));
    end

    // Extended I-type ops; the base instance must trap on every one of them
    for (int i = 0; i < 4; i++) begin
      startInstr($sformatf("imm%0d", i), immOps[i], F_ADD);
      applyStimulus(1'b1, 1'b0, 1'b0, pair(IMMEX, immexV(immAlu[i], immExt[i]), ILLEGAL, illV()));
      applyStimulus(1'b1, 1'b0, 1'b0, pair(IMMWB, immwbV(immExt[i]), ILLEGAL, illV()));
      applyStimulus(1'b1, 1'b0, 1'b0, pair(FETCH, fetchV(1'b1), ILLEGAL, illV()));
    end

    startInstr("jump", OP_J, F_ADD);
    applyStimulus(1'b1, 1'b0, 1'b0, both(JEX, jexV()));
    applyStimulus(1'b1, 1'b0, 1'b0, both(FETCH, fetchV(1'b1)));

    startInstr("badfunct", OP_RTYPE, funct_t'(6'b000111));
    for (int i = 0; i < 10; i++) begin
      curOp = opcode_t'(6'($urandom_range(0, 63)));
      curFn = funct_t'(6'($urandom_range(0, 63)));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, both(ILLEGAL, illV()));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, both(FETCH, resetV()));
    applyStimulus(1'b1, 1'b0, 1'b0, both(FETCH, fetchV(1'b1)));

    // SW stalled in MEMWR, aborted by reset
    startInstr("swabort", OP_SW, F_ADD);
    applyStimulus(1'b0, 1'b0, 1'b0, both(MEMADR, memadrV()));
    applyStimulus(1'b0, 1'b0, 1'b0, both(MEMWR, memwrV()));
    applyStimulus(1'b0, 1'b0, 1'b0, one(MEMWR, memwrV()));
    applyStimulus(1'b0, 1'b0, 1'b1, both(FETCH, resetV()));
    applyStimulus(1'b1, 1'b0, 1'b0, both(FETCH, fetchV(1'b1)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
